// File: rtl/censor_mask_gen.sv
// Per-pixel censor mask generator: tracks column/row from de/vsync and flags
// pixels inside one double-buffered rectangle, one cycle after the pixel's de.
//
// state      | meaning
// WAIT_FRAME | no frame seen since reset; counters held at 0, mask forced 0
// ACTIVE     | counting pixels and masking against the active rectangle
module censor_mask_gen #(
    parameter int H_BITS = 11,
    parameter int V_BITS = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_de,
    input  logic              vid_vsync,
    input  logic [H_BITS-1:0] rect_x0,
    input  logic [H_BITS-1:0] rect_x1,
    input  logic [V_BITS-1:0] rect_y0,
    input  logic [V_BITS-1:0] rect_y1,
    input  logic              rect_en,
    input  logic              rect_load,
    output logic              mask_bit,
    output logic              mask_de,
    output logic              load_pend,
    output logic              frame_start
);

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

    localparam logic [H_BITS-1:0] X_MAX = {H_BITS{1'b1}};
    localparam logic [V_BITS-1:0] Y_MAX = {V_BITS{1'b1}};

    state_t state, state_nxt;

    logic vsync_d, de_d;
    logic vs_rise, de_fall;
    logic [H_BITS-1:0] x;
    logic [V_BITS-1:0] y;

    logic [H_BITS-1:0] sh_x0, sh_x1, act_x0, act_x1;
    logic [V_BITS-1:0] sh_y0, sh_y1, act_y0, act_y1;
    logic              sh_en, act_en;
    logic              in_rect;

    assign vs_rise = vid_vsync & ~vsync_d;
    assign de_fall = ~vid_de & de_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_FRAME;
        else        state <= state_nxt;
    end

    // Next state and rectangle hit test; an inverted range naturally never hits
    always_comb begin
        state_nxt = state;
        in_rect   = 1'b0;
        if (vs_rise) state_nxt = ACTIVE;
        if ((x >= act_x0) && (x <= act_x1) && (y >= act_y0) && (y <= act_y1))
            in_rect = 1'b1;
    end

    // Edge-detect delays and pixel-aligned outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d     <= 1'b0;
            de_d        <= 1'b0;
            mask_de     <= 1'b0;
            mask_bit    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vsync_d     <= vid_vsync;
            de_d        <= vid_de;
            mask_de     <= vid_de;
            mask_bit    <= (state == ACTIVE) & vid_de & act_en & in_rect;
            frame_start <= vs_rise;
        end
    end

    // Column/row counters; vsync clear takes priority over the row step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (state == WAIT_FRAME) begin
            x <= '0;
            y <= '0;
        end else begin
            if (vs_rise || de_fall)     x <= '0;
            else if (vid_de && x != X_MAX) x <= x + 1'b1;

            if (vs_rise)                   y <= '0;
            else if (de_fall && y != Y_MAX) y <= y + 1'b1;
        end
    end

    // Shadow capture; a load coincident with apply keeps the new value pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x0     <= '0;
            sh_x1     <= '0;
            sh_y0     <= '0;
            sh_y1     <= '0;
            sh_en     <= 1'b0;
            load_pend <= 1'b0;
        end else if (rect_load) begin
            sh_x0     <= rect_x0;
            sh_x1     <= rect_x1;
            sh_y0     <= rect_y0;
            sh_y1     <= rect_y1;
            sh_en     <= rect_en;
            load_pend <= 1'b1;
        end else if (vs_rise) begin
            load_pend <= 1'b0;
        end
    end

    // Active rectangle swaps in only at a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x0 <= '0;
            act_x1 <= '0;
            act_y0 <= '0;
            act_y1 <= '0;
            act_en <= 1'b0;
        end else if (vs_rise && load_pend) begin
            act_x0 <= sh_x0;
            act_x1 <= sh_x1;
            act_y0 <= sh_y0;
            act_y1 <= sh_y1;
            act_en <= sh_en;
        end
    end

endmodule

// File: tb/tb_censor_mask_gen.sv
// Directed bench for censor_mask_gen: 8x4 frames with hand-chosen rectangles.
module tb_censor_mask_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_de, vid_vsync, rect_en, rect_load;
    logic [10:0] rect_x0, rect_x1, rect_y0, rect_y1;
    logic        mask_bit, mask_de, load_pend, frame_start;

    int checks = 0;
    int errors = 0;

    censor_mask_gen #(.H_BITS(11), .V_BITS(11)) dut (
        .clk(clk), .rst_n(rst_n), .vid_de(vid_de), .vid_vsync(vid_vsync),
        .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
        .rect_en(rect_en), .rect_load(rect_load),
        .mask_bit(mask_bit), .mask_de(mask_de), .load_pend(load_pend),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1, input logic en);
        rect_x0 = 11'(x0); rect_x1 = 11'(x1);
        rect_y0 = 11'(y0); rect_y1 = 11'(y1);
        rect_en = en;
    endtask

    task automatic pulse_load();
        rect_load = 1'b1; vid_de = 1'b0;
        step();
        rect_load = 1'b0;
    endtask

    // One 8x4 frame. Expected rectangle and hit count are hand-supplied.
    // ld_mid pulses rect_load at row 1 col 3; ld_vs pulses it with the vsync rise.
    task automatic frame(input int ex0, input int ex1, input int ey0, input int ey1,
                         input bit een, input int exp_cnt, input bit ld_mid, input bit ld_vs);
        int  cnt = 0;
        bit  e;
        vid_vsync = 1'b1; vid_de = 1'b0; rect_load = ld_vs;
        step();
        check("frame_start_pulse", frame_start, 1);
        rect_load = 1'b0;
        step();
        check("frame_start_once", frame_start, 0);
        vid_vsync = 1'b0;
        step(); step();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                vid_de = 1'b1;
                rect_load = ld_mid && r == 1 && c == 3;
                step();
                e = een && ex0 <= c && c <= ex1 && ey0 <= r && r <= ey1;
                check("mask_de_hi", mask_de, 1);
                check($sformatf("mask_r%0d_c%0d", r, c), mask_bit, e);
                cnt += int'(mask_bit);
            end
            vid_de = 1'b0; rect_load = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                check("mask_de_lo", mask_de, 0);
                check("mask_blank", mask_bit, 0);
            end
        end
        check("frame_mask_count", cnt, exp_cnt);
    endtask

    initial begin
        rst_n = 1'b0; vid_de = 1'b0; vid_vsync = 1'b0; rect_load = 1'b0;
        set_rect(0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mask_bit", mask_bit, 0);
        check("rst_mask_de", mask_de, 0);
        check("rst_load_pend", load_pend, 0);
        check("rst_frame_start", frame_start, 0);
        rst_n = 1'b1;
        step();

        // 1: no rectangle loaded
        for (int f = 0; f < 3; f++) frame(0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        check("t1_pend", load_pend, 0);

        // 2/3: load (2,1)-(4,2), then reload full frame mid-frame
        set_rect(2, 4, 1, 2, 1'b1);
        pulse_load();
        check("t2_pend_set", load_pend, 1);
        step();
        check("t2_pend_hold", load_pend, 1);
        set_rect(0, 7, 0, 3, 1'b1);
        frame(2, 4, 1, 2, 1'b1, 6, 1'b1, 1'b0);
        check("t3_pend_mid", load_pend, 1);
        frame(0, 7, 0, 3, 1'b1, 32, 1'b0, 1'b0);
        check("t3_pend_clr", load_pend, 0);

        // 4: inverted X range
        set_rect(5, 3, 0, 3, 1'b1);
        pulse_load();
        frame(5, 3, 0, 3, 1'b1, 0, 1'b0, 1'b0);

        // 5: load coincident with vsync rise
        set_rect(1, 1, 0, 3, 1'b1);
        pulse_load();
        set_rect(6, 7, 2, 2, 1'b1);
        frame(1, 1, 0, 3, 1'b1, 4, 1'b0, 1'b1);
        check("t5_pend_between", load_pend, 1);
        frame(6, 7, 2, 2, 1'b1, 2, 1'b0, 1'b0);
        check("t5_pend_clr", load_pend, 0);

        // 6: async reset mid-line with mask active
        set_rect(0, 7, 0, 3, 1'b1);
        pulse_load();
        frame(0, 7, 0, 3, 1'b1, 32, 1'b0, 1'b0);
        vid_vsync = 1'b1; step();
        vid_vsync = 1'b0; step();
        vid_de = 1'b1; step(); step(); step();
        check("t6_mask_before_rst", mask_bit, 1);
        rect_load = 1'b1; step(); rect_load = 1'b0;
        check("t6_pend_before_rst", load_pend, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_mask", mask_bit, 0);
        check("t6_async_de", mask_de, 0);
        check("t6_pend_lost", load_pend, 0);
        step();
        rst_n = 1'b1;
        pulse_load();
        check("t6_pend_reload", load_pend, 1);
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < 8; c++) begin
                vid_de = 1'b1; step();
                check("t6_wait_de", mask_de, 1);
                check("t6_wait_nomask", mask_bit, 0);
            end
            vid_de = 1'b0; step(); step();
        end
        frame(0, 7, 0, 3, 1'b1, 32, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
